// File: rtl/seq_ctrl_pkg.sv
// Shared types and default widths for the sequence controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package seq_ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int LEN_W  = 8;
    localparam int DIV_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        STEP,
        CAPTURE,
        HOLD,
        DONE
    } state_t;

endpackage

// File: rtl/sequence_controller_step_timer.sv
// Interval down-counter: load a value, decrement on request, flag zero.
// Latency: load/decrement visible the cycle after the request; zero flag is combinational on the count.
// Backpressure: none; decrement saturates at zero.
module step_timer #(
    parameter int W = seq_ctrl_pkg::DIV_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Load has priority over decrement; count never goes below zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/sequence_controller.sv
// Paces the sequence generator per run command and streams each captured value out.
// Latency: first out_valid div+4 cycles after command accept, then every div+4 cycles with out_ready high.
// Backpressure: a pending value is held in HOLD; no further step is issued until it is taken.
module sequence_controller #(
    parameter int DATA_W = seq_ctrl_pkg::DATA_W,
    parameter int LEN_W  = seq_ctrl_pkg::LEN_W,
    parameter int DIV_W  = seq_ctrl_pkg::DIV_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DIV_W-1:0]  cmd_div,
    input  logic              abort,
    output logic              seq_enable,
    output logic              seq_step,
    input  logic [DATA_W-1:0] seq_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    import seq_ctrl_pkg::*;

    state_t             state;
    state_t             state_n;
    logic [LEN_W-1:0]   remaining;
    logic [DIV_W-1:0]   div_q;
    logic               accept;
    logic               abort_act;
    logic               xfer;
    logic               tmr_load;
    logic [DIV_W-1:0]   tmr_load_val;
    logic               tmr_dec;
    logic               tmr_zero;

    assign accept    = (state == IDLE) && cmd_valid && cmd_ready;
    // Abort only has meaning while a run is actually in flight.
    assign abort_act = abort && (state != IDLE) && (state != DONE);
    assign xfer      = out_valid && out_ready;

    step_timer #(
        .W (DIV_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // Next-state selection and interval timer control.
    always_comb begin
        state_n      = state;
        tmr_load     = 1'b0;
        tmr_load_val = div_q;
        tmr_dec      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_len == '0) begin
                        state_n = DONE;
                    end else begin
                        state_n      = WAIT;
                        tmr_load     = 1'b1;
                        tmr_load_val = cmd_div;
                    end
                end
            end
            WAIT: begin
                if (abort_act) begin
                    state_n = DONE;
                end else if (tmr_zero) begin
                    state_n = STEP;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            STEP: begin
                state_n = abort_act ? DONE : CAPTURE;
            end
            CAPTURE: begin
                state_n = abort_act ? DONE : HOLD;
            end
            HOLD: begin
                if (abort_act) begin
                    state_n = DONE;
                end else if (xfer) begin
                    if (out_last) begin
                        state_n = DONE;
                    end else begin
                        state_n  = WAIT;
                        tmr_load = 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State register, registered control outputs and the output data stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cmd_ready  <= 1'b0;
            busy       <= 1'b0;
            seq_enable <= 1'b0;
            seq_step   <= 1'b0;
            done       <= 1'b0;
            remaining  <= '0;
            div_q      <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
        end else begin
            state      <= state_n;
            cmd_ready  <= (state_n == IDLE);
            busy       <= (state_n != IDLE);
            seq_enable <= (state_n == WAIT) || (state_n == STEP) ||
                          (state_n == CAPTURE) || (state_n == HOLD);
            seq_step   <= (state_n == STEP);
            done       <= (state_n == DONE);

            if (accept) begin
                remaining <= cmd_len;
                div_q     <= cmd_div;
            end

            // seq_data reflects the step issued last cycle; an aborted capture is dropped.
            if ((state == CAPTURE) && !abort_act) begin
                out_data  <= seq_data;
                out_valid <= 1'b1;
                out_last  <= (remaining == LEN_W'(1));
                remaining <= remaining - LEN_W'(1);
            end else if (out_valid && (out_ready || abort_act)) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sequence_controller.sv
// Directed self-checking bench for sequence_controller with a counting generator model.
// Latency: checks exact cycle offsets from command accept.
// Backpressure: exercises out_ready stalls and abort during a held value.
module tb_sequence_controller;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_len;
    logic [15:0] cmd_div;
    logic        abort;
    logic        seq_enable;
    logic        seq_step;
    logic [7:0]  seq_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    sequence_controller #(
        .DATA_W (8),
        .LEN_W  (8),
        .DIV_W  (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .cmd_div    (cmd_div),
        .abort      (abort),
        .seq_enable (seq_enable),
        .seq_step   (seq_step),
        .seq_data   (seq_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Generator model: counts up from 0x10 on each strobe, never reset by the controller.
    logic [7:0] gen = 8'h10;
    always @(posedge clk) if (seq_enable && seq_step) gen <= gen + 8'd1;
    assign seq_data = gen;

    // Event log sampled mid-cycle.
    int         step_q[$];
    int         rise_q[$];
    logic [7:0] hs_data[$];
    logic       hs_last[$];
    int         acc_cnt = 0;
    int         t_acc = 0;
    logic       prev_valid = 1'b0;

    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) begin
            acc_cnt <= acc_cnt + 1;
            t_acc   <= cyc;
        end
        if (seq_step) step_q.push_back(cyc);
        if (out_valid && !prev_valid) rise_q.push_back(cyc);
        if (out_valid && out_ready) begin
            hs_data.push_back(out_data);
            hs_last.push_back(out_last);
        end
        prev_valid <= out_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] len, input logic [15:0] div, input bit keep_valid);
        int n = 0;
        cmd_len   = len;
        cmd_div   = div;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            tick(1);
            n++;
        end
        check("cmd_accept", 32'(cmd_ready), 1);
        tick(1);
        if (!keep_valid) cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 32'(out_valid), 1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 32'(done), 1);
    endtask

    initial begin
        int t;
        int sr;
        int ss;
        int sh;
        int sa;
        int bad;

        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        cmd_div   = '0;
        abort     = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #3;
        check("rst_cmd_ready", 32'(cmd_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_seq_enable", 32'(seq_enable), 0);
        check("rst_done", 32'(done), 0);
        tick(2);
        reset = 1'b1;
        check("rel_cmd_ready_pre", 32'(cmd_ready), 0);
        tick(1);
        check("rel_cmd_ready_post", 32'(cmd_ready), 1);

        // Test 1: len 3, div 0, consumer always ready
        out_ready = 1'b1;
        sr = rise_q.size();
        sh = hs_data.size();
        send_cmd(8'd3, 16'd0, 1'b0);
        t = t_acc;
        wait_done("t1_done_seen", 100);
        check("t1_done_cyc", 32'(cyc - t), 13);
        check("t1_ready_in_done", 32'(cmd_ready), 0);
        check("t1_busy_in_done", 32'(busy), 1);
        tick(1);
        check("t1_ready_after", 32'(cmd_ready), 1);
        check("t1_busy_after", 32'(busy), 0);
        check("t1_rise_cnt", 32'(rise_q.size() - sr), 3);
        check("t1_hs_cnt", 32'(hs_data.size() - sh), 3);
        for (int i = 0; i < 3 && (sr + i) < rise_q.size(); i++)
            check("t1_rise_cyc", 32'(rise_q[sr + i] - t), 32'(4 * (i + 1)));
        for (int i = 0; i < 3 && (sh + i) < hs_data.size(); i++) begin
            check("t1_data", 32'(hs_data[sh + i]), 32'(8'h11 + i));
            check("t1_last", 32'(hs_last[sh + i]), (i == 2) ? 1 : 0);
        end

        // Test 2: len 2, div 5, step spacing
        ss = step_q.size();
        sh = hs_data.size();
        send_cmd(8'd2, 16'd5, 1'b0);
        t = t_acc;
        wait_done("t2_done_seen", 200);
        tick(1);
        check("t2_step_cnt", 32'(step_q.size() - ss), 2);
        if (step_q.size() - ss >= 2) begin
            check("t2_step0_cyc", 32'(step_q[ss] - t), 7);
            check("t2_step_gap", 32'(step_q[ss + 1] - step_q[ss]), 9);
        end
        check("t2_hs_cnt", 32'(hs_data.size() - sh), 2);
        if (hs_data.size() - sh >= 2) begin
            check("t2_data0", 32'(hs_data[sh]), 32'h14);
            check("t2_data1", 32'(hs_data[sh + 1]), 32'h15);
        end

        // Test 3: stall the first value for 10 cycles
        out_ready = 1'b0;
        sh = hs_data.size();
        send_cmd(8'd4, 16'd0, 1'b0);
        wait_valid("t3_first_valid", 50);
        check("t3_first_data", 32'(out_data), 32'h16);
        ss = step_q.size();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (!out_valid || out_data !== 8'h16 || out_last !== 1'b0) bad++;
        end
        check("t3_stall_stable", 32'(bad), 0);
        check("t3_stall_no_step", 32'(step_q.size() - ss), 0);
        out_ready = 1'b1;
        wait_done("t3_done_seen", 200);
        tick(1);
        check("t3_hs_cnt", 32'(hs_data.size() - sh), 4);
        for (int i = 0; i < 4 && (sh + i) < hs_data.size(); i++) begin
            check("t3_data", 32'(hs_data[sh + i]), 32'(8'h16 + i));
            check("t3_last", 32'(hs_last[sh + i]), (i == 3) ? 1 : 0);
        end

        // Test 4: empty run
        sr = rise_q.size();
        ss = step_q.size();
        send_cmd(8'd0, 16'd0, 1'b0);
        check("t4_done_offset", 32'(cyc - t_acc), 1);
        check("t4_done_t1", 32'(done), 1);
        check("t4_busy_t1", 32'(busy), 1);
        check("t4_ready_t1", 32'(cmd_ready), 0);
        tick(1);
        check("t4_done_t2", 32'(done), 0);
        check("t4_busy_t2", 32'(busy), 0);
        check("t4_ready_t2", 32'(cmd_ready), 1);
        tick(3);
        check("t4_no_step", 32'(step_q.size() - ss), 0);
        check("t4_no_valid", 32'(rise_q.size() - sr), 0);

        // Test 5: abort while the 2nd value is held, with a stray command pending
        out_ready = 1'b1;
        ss = step_q.size();
        sh = hs_data.size();
        sa = acc_cnt;
        send_cmd(8'd5, 16'd0, 1'b1);
        t = t_acc;
        cmd_len = 8'd7;
        cmd_div = 16'd3;
        wait_valid("t5_v1", 50);
        check("t5_v1_data", 32'(out_data), 32'h1A);
        tick(1);
        out_ready = 1'b0;
        wait_valid("t5_v2", 50);
        check("t5_v2_cyc", 32'(cyc - t), 8);
        check("t5_v2_data", 32'(out_data), 32'h1B);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        cmd_valid = 1'b0;
        check("t5_valid_cleared", 32'(out_valid), 0);
        check("t5_done", 32'(done), 1);
        check("t5_enable_cleared", 32'(seq_enable), 0);
        tick(4);
        check("t5_step_cnt", 32'(step_q.size() - ss), 2);
        check("t5_accept_cnt", 32'(acc_cnt - sa), 1);
        check("t5_hs_cnt", 32'(hs_data.size() - sh), 1);
        check("t5_idle", 32'(busy), 0);

        // Test 6: asynchronous reset in WAIT, then a single-value run
        out_ready = 1'b1;
        send_cmd(8'd1, 16'd20, 1'b0);
        tick(3);
        check("t6_in_wait", 32'(seq_enable), 1);
        #2;
        reset = 1'b0;
        #1;
        check("t6_rst_enable", 32'(seq_enable), 0);
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_ready", 32'(cmd_ready), 0);
        tick(2);
        reset = 1'b1;
        tick(1);
        check("t6_ready_back", 32'(cmd_ready), 1);
        sh = hs_data.size();
        send_cmd(8'd1, 16'd0, 1'b0);
        wait_done("t6_done_seen", 100);
        tick(1);
        check("t6_hs_cnt", 32'(hs_data.size() - sh), 1);
        if (hs_data.size() - sh >= 1) begin
            check("t6_data", 32'(hs_data[sh]), 32'h1C);
            check("t6_last", 32'(hs_last[sh]), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sequence_controller.md
Name: sequence_controller

Overview:
Command-driven scheduler for the 8-bit sequence generator datapath. It accepts a run command (step count plus step interval) and paces the generator with an enable and a one-cycle step strobe. Each generated value is captured and streamed out on a valid/ready interface, with full backpressure. It sits between the host/config logic and the generator, and owns when the generator advances.

Parameters:
DATA_W, 8, width of generator value and output data
LEN_W, 8, width of step-count field
DIV_W, 16, width of step-interval field

Ports:
clk  input  1  system clock, single clock domain
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  run command offered
cmd_ready  output  1  controller idle, command can be accepted
cmd_len  input  LEN_W  number of values to produce; 0 = empty run
cmd_div  input  DIV_W  idle cycles before each step (interval control)
abort  input  1  terminate current run
seq_enable  output  1  enable to generator datapath
seq_step  output  1  one-cycle strobe advancing generator by one value
seq_data  input  DATA_W  current generator value, valid the cycle after seq_step
out_valid  output  1  out_data holds a value
out_ready  input  1  consumer accepts value
out_data  output  DATA_W  captured value
out_last  output  1  marks final value of run, qualified by out_valid
busy  output  1  run in progress
done  output  1  one-cycle pulse at end of run (normal, empty or aborted)

Behaviour:
- Reset (reset low, async): state IDLE. All outputs 0, including cmd_ready. Latched len/div and the counters are cleared. cmd_ready becomes 1 on the first clk edge after release.
- States: IDLE, WAIT, STEP, CAPTURE, HOLD, DONE. busy = (state != IDLE). seq_enable = 1 in WAIT, STEP, CAPTURE and HOLD.
- IDLE: cmd_ready=1.
  - On cmd_valid && cmd_ready (cycle T): latch remaining=cmd_len, div=cmd_div.
  - If cmd_len==0, go to DONE.
  - Otherwise load timer with div and go to WAIT.
- WAIT: timer decrements each cycle; go to STEP in the cycle after timer==0.
- STEP: seq_step=1 for exactly one cycle, then go to CAPTURE.
- CAPTURE: register out_data<=seq_data, out_valid<=1, out_last<=(remaining==1); decrement remaining; go to HOLD.
- HOLD: out_valid, out_data and out_last are held stable until out_valid && out_ready.
  - On handshake with out_last=1: go to DONE.
  - On handshake with out_last=0: reload timer and go to WAIT.
  - out_valid falls in the cycle after the handshake.
- DONE: done=1 for one cycle, then go to IDLE. cmd_ready=0 in DONE, so the earliest next accept is the cycle after done.
- Latency: first out_valid at T+div+4. With out_ready held high, successive values arrive every div+4 cycles.
- Backpressure: no seq_step is issued while a value is pending in HOLD. No values are lost or duplicated.
- abort in any state other than IDLE/DONE:
  - Next state is DONE; out_valid, out_last and seq_enable are cleared the next cycle; no further seq_step.
  - If abort coincides with a handshake, the transfer counts as completed.
  - If abort coincides with STEP, the strobe still fires that cycle, but its value is discarded.
- abort in IDLE or DONE is ignored. An abort coinciding with command acceptance is ignored, and the command starts normally.
- cmd_valid while busy is not accepted. cmd_len/cmd_div are sampled only at acceptance.
- Counters: remaining is LEN_W bits and never wraps, since runs end at remaining 1→0. The timer saturates at 0.
- The generator's own value is not reset by this block; runs continue the generator sequence.

Decomposition:
- Package seq_ctrl_pkg holds:
  - the state enum (IDLE, WAIT, STEP, CAPTURE, HOLD, DONE);
  - default width constants DATA_W=8, LEN_W=8, DIV_W=16.
- Sub-module step_timer (DIV_W down-counter with load, decrement enable and zero flag) is instantiated once.

Test Plan:
- cmd_len=3, cmd_div=0, out_ready=1, generator model counting up from 0x10 → out_data 0x11, 0x12, 0x13 with out_valid rising at T+4, T+8, T+12; out_last only on 0x13; done one cycle after the last handshake; cmd_ready back 1 the cycle after done.
- cmd_len=2, cmd_div=5, out_ready=1 → seq_step pulses spaced 9 cycles apart, first at T+7; exactly 2 seq_step pulses total.
- cmd_len=4, out_ready held 0 for 10 cycles after the first out_valid → out_valid and out_data stable all 10 cycles; no seq_step during the stall; all 4 values delivered in order once ready returns.
- cmd_len=0 → no seq_step, no out_valid; done=1 at T+1, busy high only at T+1, cmd_ready=1 at T+2.
- cmd_len=5, abort asserted in HOLD after the 2nd value with out_ready=0 → out_valid 0 next cycle, done pulse, no further seq_step; a second cmd_valid during the run is never accepted.
- reset driven low mid-run (in WAIT) → all outputs 0 immediately without a clock edge; after release, a cmd_len=1 run completes normally.
